// File: rtl/input_conditioner_bank_if.sv
// Bundle of the raw inputs and the conditioned outputs of input_conditioner_bank.
// The master drives the raw pins; the slave (the conditioner) produces clean levels and pulses.
interface input_conditioner_bank_if #(
   parameter int NCH = 3
);
   logic [NCH-1:0] noisy;
   logic [NCH-1:0] conditioned;
   logic [NCH-1:0] posedge_pulse;
   logic [NCH-1:0] negedge_pulse;
   logic           any_edge;

   modport master (
      output noisy,
      input  conditioned,
      input  posedge_pulse,
      input  negedge_pulse,
      input  any_edge
   );

   modport slave (
      input  noisy,
      output conditioned,
      output posedge_pulse,
      output negedge_pulse,
      output any_edge
   );
endinterface

// File: rtl/input_conditioner_bank.sv
// Synchronises, debounces and edge-detects a bank of raw board inputs.
// A channel's level changes only after WAIT_CYCLES consecutive differing synchronised samples.
module input_conditioner_bank #(
   parameter int NCH         = 3,
   parameter int WAIT_CYCLES = 3,
   parameter int CNT_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input_conditioner_bank_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WAIT_CYCLES - 1);

   logic [NCH-1:0]       sync1_p0;
   logic [NCH-1:0]       sync2_p1;
   logic [NCH-1:0]       level_p2;
   logic [NCH-1:0]       rise_p2;
   logic [NCH-1:0]       fall_p2;
   logic [CNT_WIDTH-1:0] cnt_p2 [NCH];

   // Stage p0/p1: two-flop synchroniser on the asynchronous pins
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_p0 <= '0;
         sync2_p1 <= '0;
      end else begin
         sync1_p0 <= bus.noisy;
         sync2_p1 <= sync1_p0;
      end
   end

   // Stage p2: stability counter, level register and edge pulses per channel
   always_ff @(posedge clk) begin
      if (reset) begin
         level_p2 <= '0;
         rise_p2  <= '0;
         fall_p2  <= '0;
         for (int i = 0; i < NCH; i++) cnt_p2[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (sync2_p1[i] == level_p2[i]) begin
               cnt_p2[i]  <= '0;
               rise_p2[i] <= 1'b0;
               fall_p2[i] <= 1'b0;
            end else if (cnt_p2[i] == CNT_LAST) begin
               level_p2[i] <= sync2_p1[i];
               cnt_p2[i]   <= '0;
               rise_p2[i]  <= sync2_p1[i];
               fall_p2[i]  <= ~sync2_p1[i];
            end else begin
               cnt_p2[i]  <= cnt_p2[i] + 1'b1;
               rise_p2[i] <= 1'b0;
               fall_p2[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.conditioned   = level_p2;
   assign bus.posedge_pulse = rise_p2;
   assign bus.negedge_pulse = fall_p2;
   assign bus.any_edge      = |(rise_p2 | fall_p2);
endmodule

// File: tb/tb_input_conditioner_bank.sv
// Bench for input_conditioner_bank: directed vector table, corner-case sequences,
// and random stimulus against a "last W synchronised samples all differ" reference model.
module tb_input_conditioner_bank;
   localparam int NCH = 3;
   localparam int W   = 3;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   input_conditioner_bank_if #(.NCH(NCH)) bus ();

   input_conditioner_bank #(
      .NCH        (NCH),
      .WAIT_CYCLES(W),
      .CNT_WIDTH  (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pins reach the debouncer two edges late (zeroed by reset);
   // a level flips once the last W observed samples all disagree with it.
   logic [NCH-1:0] m_pipe [2];
   logic [NCH-1:0] m_seen [$];
   logic [NCH-1:0] m_level;
   logic [NCH-1:0] m_rise;
   logic [NCH-1:0] m_fall;

   task automatic model_edge(input logic [NCH-1:0] n, input logic r);
      logic [NCH-1:0] obs;
      logic           all_diff;
      if (r) begin
         m_pipe[0] = '0;
         m_pipe[1] = '0;
         m_seen    = {};
         for (int j = 0; j < W; j++) m_seen.push_back('0);
         m_level = '0;
         m_rise  = '0;
         m_fall  = '0;
      end else begin
         obs       = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = n;
         m_seen.push_back(obs);
         void'(m_seen.pop_front());
         m_rise = '0;
         m_fall = '0;
         for (int c = 0; c < NCH; c++) begin
            all_diff = 1'b1;
            foreach (m_seen[j]) if (m_seen[j][c] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[c] = ~m_level[c];
               m_rise[c]  = m_level[c];
               m_fall[c]  = ~m_level[c];
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic [NCH-1:0] n, input logic r);
      @(negedge clk);
      bus.noisy = n;
      reset     = r;
      @(posedge clk);
      model_edge(n, r);
      #1;
      check("model_cond", 8'(bus.conditioned), 8'(m_level));
      check("model_pos", 8'(bus.posedge_pulse), 8'(m_rise));
      check("model_neg", 8'(bus.negedge_pulse), 8'(m_fall));
      check("model_any", 8'(bus.any_edge), 8'(|(m_rise | m_fall)));
      check("exclusive", 8'(bus.posedge_pulse & bus.negedge_pulse), 8'h00);
   endtask

   typedef struct {
      logic           rst;
      logic [NCH-1:0] noisy;
      logic [NCH-1:0] cond;
      logic [NCH-1:0] pos;
      logic [NCH-1:0] neg;
      logic           any;
   } vec_t;

   vec_t tbl [20];

   initial begin
      int first;
      int cnt_a;
      int cnt_b;
      logic [NCH-1:0] rnd;
      logic           rrst;

      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      bus.noisy = '0;

      // Reset with all pins high, refill + count, release all, clean press on ch0
      tbl[0]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[1]  = '{1'b1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[2]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[3]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[4]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[5]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[6]  = '{1'b0, 3'b111, 3'b111, 3'b111, 3'b000, 1'b1};
      tbl[7]  = '{1'b0, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0};
      tbl[8]  = '{1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0};
      tbl[9]  = '{1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0};
      tbl[10] = '{1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0};
      tbl[11] = '{1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0};
      tbl[12] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1};
      tbl[13] = '{1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[14] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[15] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[16] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[17] = '{1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0};
      tbl[18] = '{1'b0, 3'b001, 3'b001, 3'b001, 3'b000, 1'b1};
      tbl[19] = '{1'b0, 3'b001, 3'b001, 3'b000, 3'b000, 1'b0};

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].noisy, tbl[i].rst);
         check($sformatf("tbl%0d_cond", i), 8'(bus.conditioned), 8'(tbl[i].cond));
         check($sformatf("tbl%0d_pos", i), 8'(bus.posedge_pulse), 8'(tbl[i].pos));
         check($sformatf("tbl%0d_neg", i), 8'(bus.negedge_pulse), 8'(tbl[i].neg));
         check($sformatf("tbl%0d_any", i), 8'(bus.any_edge), 8'(tbl[i].any));
      end

      // Bounce on ch0: release, toggle six cycles, then hold high
      for (int i = 0; i < 8; i++) step(3'b000, 1'b0);
      cnt_a = 0;
      for (int i = 0; i < 6; i++) begin
         step((i % 2 == 0) ? 3'b001 : 3'b000, 1'b0);
         cnt_a += int'(bus.posedge_pulse[0]) + int'(bus.negedge_pulse[0]);
      end
      check_int("bounce_quiet", cnt_a, 0);
      first = -1;
      cnt_a = 0;
      for (int i = 0; i < 8; i++) begin
         step(3'b001, 1'b0);
         if (bus.posedge_pulse[0] && first < 0) first = i;
         cnt_a += int'(bus.posedge_pulse[0]);
      end
      check_int("bounce_latency", first, 4);
      check_int("bounce_count", cnt_a, 1);

      // Short glitch on ch1
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         step((i < 2) ? 3'b011 : 3'b001, 1'b0);
         cnt_a += int'(bus.posedge_pulse[1]) + int'(bus.negedge_pulse[1]);
         cnt_b += int'(bus.conditioned[1]);
      end
      check_int("glitch_pulses", cnt_a, 0);
      check_int("glitch_level", cnt_b, 0);

      // Reset mid-count on ch2: rise before E0, reset at E2
      first = -1;
      cnt_a = 0;
      for (int e = 0; e < 11; e++) begin
         step(3'b101, (e == 2) ? 1'b1 : 1'b0);
         if (e == 4) cnt_a = int'(bus.posedge_pulse[2]);
         if (bus.posedge_pulse[2] && first < 0) first = e;
      end
      check_int("rst_mid_no_e4", cnt_a, 0);
      check_int("rst_mid_latency", first, 7);

      // Random pins with occasional resets
      rnd = 3'b101;
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(5) == 0) rnd[c] = ~rnd[c];
         rrst = ($urandom_range(49) == 0);
         step(rnd, rrst);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
